// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: shares one fp16 sqrt pipeline among NUM_REQ requesters.
// Round-robin grant with a credit limit of MAX_INFLIGHT outstanding ops.
// An in-order tag FIFO records who issued each op so results route back.
// The sqrt unit only advances when fed, so filler ops (FILLER_VAL) are
// injected while real ops are in flight; their results are dropped.
// Optional build macro SQRT_ARB_PERF_EN adds perf_issued / perf_filler /
// perf_stall event counters.
module sqrt_arbiter #(
    parameter int          NUM_REQ      = 4,
    parameter int          MAX_INFLIGHT = 8,
    parameter logic [15:0] FILLER_VAL   = 16'h3C00
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_data,
    output logic                   sqrt_valid_in,
    output logic [15:0]            sqrt_input,
    input  logic                   sqrt_valid_out,
    input  logic [15:0]            sqrt_output,
    output logic                   busy,
    output logic                   tag_err
`ifdef SQRT_ARB_PERF_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_filler,
    output logic [31:0]            perf_stall
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_INFLIGHT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_WIDE = (IDX_W + 1)'(NUM_REQ);

    // Round-robin pointer: requester index that has first claim this cycle.
    logic [IDX_W-1:0] rr_ptr;

    // Tag FIFO: one entry per op handed to the sqrt unit, oldest at rd_ptr.
    logic             tag_filler [MAX_INFLIGHT];
    logic [IDX_W-1:0] tag_idx    [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] real_count;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [15:0]      grant_data;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_sel;

    logic             credit_ok;
    logic             accept;
    logic             filler_issue;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             head_filler;
    logic [IDX_W-1:0] head_idx;
    logic [NUM_REQ-1:0] head_onehot;

    assign credit_ok    = (count < CNT_MAX);
    assign fifo_empty   = (count == '0);
    assign accept       = grant_found & credit_ok;
    assign filler_issue = ~accept & (real_count != '0) & credit_ok;
    assign push         = accept | filler_issue;
    assign pop          = sqrt_valid_out & ~fifo_empty;
    assign head_filler  = tag_filler[rd_ptr];
    assign head_idx     = tag_idx[rd_ptr];
    assign busy         = ~fifo_empty;

    // Scan req_valid from rr_ptr upward with wrap; first set bit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_sel    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (scan_sum >= NUM_WIDE) begin
                scan_sum = scan_sum - NUM_WIDE;
            end
            scan_sel = scan_sum[IDX_W-1:0];
            if (!grant_found && req_valid[scan_sel]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sel;
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_data = req_data[16*i +: 16];
            end
        end
    end

    // Ready is one-hot on the winner, and only when a credit is free.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // One-hot decode of the head tag's requester index.
    always_comb begin
        head_onehot = '0;
        head_onehot[head_idx] = 1'b1;
    end

    // Registered issue to the sqrt unit; operand holds when idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sqrt_valid_in <= 1'b0;
            sqrt_input    <= '0;
        end else begin
            sqrt_valid_in <= push;
            if (accept) begin
                sqrt_input <= grant_data;
            end else if (filler_issue) begin
                sqrt_input <= FILLER_VAL;
            end
        end
    end

    // Tag storage; contents are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge CLK) begin
        if (push) begin
            tag_filler[wr_ptr] <= filler_issue;
            tag_idx[wr_ptr]    <= grant_idx;
        end
    end

    // FIFO pointers, occupancy and count of real (non-filler) ops in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            real_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            case ({accept, pop & ~head_filler})
                2'b10:   real_count <= real_count + CNT_W'(1);
                2'b01:   real_count <= real_count - CNT_W'(1);
                default: real_count <= real_count;
            endcase
        end
    end

    // Route results: real tags produce a 1-cycle one-hot strobe, fillers vanish.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            tag_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (pop && !head_filler) begin
                rsp_valid <= head_onehot;
                rsp_data  <= sqrt_output;
            end
            if (sqrt_valid_out && fifo_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

    // Pointer moves just past the requester that was accepted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
        end
    end

`ifdef SQRT_ARB_PERF_EN
    // Free-running wrapping event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_issued <= '0;
            perf_filler <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if (filler_issue) begin
                perf_filler <= perf_filler + 32'd1;
            end
            if ((|req_valid) && !credit_ok) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Testbench for sqrt_arbiter: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model. The sqrt
// unit is a small stub that only advances on valid inputs; it can be bypassed
// so sequences drive sqrt_valid_out/sqrt_output directly.
module tb_sqrt_arbiter;

    localparam int          N        = 4;
    localparam int          MAXI     = 8;
    localparam logic [15:0] FILL     = 16'h3C00;
    localparam int          SQ_DEPTH = 4;

    logic                CLK = 1'b0;
    logic                RST;
    logic [N-1:0]        req_valid;
    logic [16*N-1:0]     req_data;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    logic [15:0]         rsp_data;
    logic                sqrt_valid_in;
    logic [15:0]         sqrt_input;
    logic                sqrt_valid_out;
    logic [15:0]         sqrt_output;
    logic                busy;
    logic                tag_err;
`ifdef SQRT_ARB_PERF_EN
    logic [31:0]         perf_issued;
    logic [31:0]         perf_filler;
    logic [31:0]         perf_stall;
`endif

    always #5 CLK = ~CLK;

    sqrt_arbiter #(
        .NUM_REQ      (N),
        .MAX_INFLIGHT (MAXI),
        .FILLER_VAL   (FILL)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .sqrt_valid_in  (sqrt_valid_in),
        .sqrt_input     (sqrt_input),
        .sqrt_valid_out (sqrt_valid_out),
        .sqrt_output    (sqrt_output),
        .busy           (busy),
        .tag_err        (tag_err)
`ifdef SQRT_ARB_PERF_EN
        ,
        .perf_issued    (perf_issued),
        .perf_filler    (perf_filler),
        .perf_stall     (perf_stall)
`endif
    );

    // ---------------- sqrt stub ----------------
    function automatic logic [15:0] fake_sqrt(input logic [15:0] x);
        if (x == 16'h4400) return 16'h4000;
        return x ^ 16'h5A5A;
    endfunction

    logic                stub_en;
    logic                man_vo;
    logic [15:0]         man_do;
    logic [SQ_DEPTH-1:0] st_v;
    logic [15:0]         st_d [SQ_DEPTH];
    logic                stub_vo;
    logic [15:0]         stub_do;

    always @(posedge CLK) begin
        if (RST) begin
            st_v    <= '0;
            stub_vo <= 1'b0;
            stub_do <= '0;
        end else begin
            stub_vo <= sqrt_valid_in & st_v[SQ_DEPTH-1];
            if (sqrt_valid_in) begin
                stub_do <= st_d[SQ_DEPTH-1];
                st_v    <= {st_v[SQ_DEPTH-2:0], 1'b1};
                st_d[0] <= fake_sqrt(sqrt_input);
                for (int k = 1; k < SQ_DEPTH; k++) st_d[k] <= st_d[k-1];
            end
        end
    end

    assign sqrt_valid_out = stub_en ? stub_vo : man_vo;
    assign sqrt_output    = stub_en ? stub_do : man_do;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_rr;
    int           m_realc;
    int           m_q[$];          // requester index, or -1 for a filler
    logic [N-1:0] m_rdy;
    logic [N-1:0] m_rsp_v;
    logic [15:0]  m_rsp_d;
    logic         m_svi;
    logic [15:0]  m_sin;
    logic         m_err;
    logic [N-1:0] last_ready;

    task automatic model_reset();
        m_rr    = 0;
        m_realc = 0;
        m_q.delete();
        m_rdy   = '0;
        m_rsp_v = '0;
        m_rsp_d = '0;
        m_svi   = 1'b0;
        m_sin   = '0;
        m_err   = 1'b0;
    endtask

    // Called just after a falling edge: apply inputs, check the grant, predict
    // the registered outputs, then check them at the next falling edge.
    task automatic run_cycle(input logic [N-1:0] rv, input logic [16*N-1:0] rd);
        int win;
        int j;
        int tag;
        bit credit;
        bit acc;
        bit fill;
        req_valid = rv;
        req_data  = rd;
        #1;
        last_ready = req_ready;
        credit = (m_q.size() < MAXI);
        win = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_rr + k) % N;
            if (win < 0 && rv[j]) win = j;
        end
        m_rdy = (credit && win >= 0) ? (N'(1) << win) : '0;
        check("req_ready", req_ready, m_rdy);
        acc  = (m_rdy != '0);
        fill = !acc && (m_realc > 0) && credit;
        m_svi = acc || fill;
        if (acc) m_sin = rd[16*win +: 16];
        else if (fill) m_sin = FILL;
        m_rsp_v = '0;
        if (sqrt_valid_out) begin
            if (m_q.size() == 0) begin
                m_err = 1'b1;
            end else begin
                tag = m_q.pop_front();
                if (tag >= 0) begin
                    m_rsp_v = N'(1) << tag;
                    m_rsp_d = sqrt_output;
                    m_realc--;
                end
            end
        end
        if (acc) begin
            m_q.push_back(win);
            m_realc++;
            m_rr = (win + 1) % N;
        end else if (fill) begin
            m_q.push_back(-1);
        end
        @(negedge CLK);
        check("rsp_valid", rsp_valid, m_rsp_v);
        check("rsp_data", rsp_data, m_rsp_d);
        check("sqrt_valid_in", sqrt_valid_in, m_svi);
        check("sqrt_input", sqrt_input, m_sin);
        check("busy", busy, m_q.size() != 0);
        check("tag_err", tag_err, m_err);
    endtask

    task automatic do_reset(input logic [N-1:0] rv);
        req_valid = rv;
        man_vo    = 1'b0;
        RST       = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_rsp_data", rsp_data, '0);
        check("rst_sqrt_valid_in", sqrt_valid_in, '0);
        check("rst_sqrt_input", sqrt_input, '0);
        check("rst_busy", busy, '0);
        check("rst_tag_err", tag_err, '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] rv;
        logic [N-1:0] rdy;
        logic         svi;
        logic [15:0]  sin;
    } vec_t;

    vec_t         tbl [10];
    logic [15:0]  tdat;
    int           pct [8];
    logic [N-1:0] cur_v;
    logic [15:0]  cur_d [N];
    logic [16*N-1:0] flat;
    int           pulses;
    int           stray;
    int           ndrain;

    initial begin
        // data for row r is 16'h4000+r on every slice
        tbl[0] = '{4'b0101, 4'b0001, 1'b1, 16'h4000};
        tbl[1] = '{4'b0101, 4'b0100, 1'b1, 16'h4001};
        tbl[2] = '{4'b0001, 4'b0001, 1'b1, 16'h4002};
        tbl[3] = '{4'b1010, 4'b0010, 1'b1, 16'h4003};
        tbl[4] = '{4'b1000, 4'b1000, 1'b1, 16'h4004};
        tbl[5] = '{4'b0000, 4'b0000, 1'b1, 16'h3C00};
        tbl[6] = '{4'b1111, 4'b0001, 1'b1, 16'h4006};
        tbl[7] = '{4'b1111, 4'b0010, 1'b1, 16'h4007};
        tbl[8] = '{4'b1111, 4'b0000, 1'b0, 16'h4007};
        tbl[9] = '{4'b0000, 4'b0000, 1'b0, 16'h4007};
        pct = '{5, 30, 80, 0, 50, 100, 10, 0};

        stub_en   = 1'b0;
        man_vo    = 1'b0;
        man_do    = '0;
        req_valid = '0;
        req_data  = '0;
        RST       = 1'b1;
        model_reset();

        // Table: grant rotation, filler insertion, credit exhaustion.
        do_reset('0);
        for (int r = 0; r < 10; r++) begin
            tdat = 16'h4000 + 16'(r);
            run_cycle(tbl[r].rv, {N{tdat}});
            check("tbl_ready", last_ready, tbl[r].rdy);
            check("tbl_svi", sqrt_valid_in, tbl[r].svi);
            check("tbl_sin", sqrt_input, tbl[r].sin);
        end

        // Full FIFO: pop does not bypass; grant resumes the following cycle.
        man_vo = 1'b1;
        man_do = 16'hABCD;
        run_cycle(4'b1111, {N{16'h5000}});
        check("full_no_grant", last_ready, 4'b0000);
        check("full_no_filler", sqrt_valid_in, 1'b0);
        check("full_rsp_valid", rsp_valid, 4'b0001);
        check("full_rsp_data", rsp_data, 16'hABCD);
        man_vo = 1'b0;
        run_cycle(4'b1111, {N{16'h5000}});
        check("credit_resume", last_ready, 4'b0100);

        // Round-robin with all requesters valid, then in-order responses.
        do_reset('0);
        for (int c = 0; c < 8; c++) begin
            run_cycle(4'b1111, {16'h6003, 16'h6002, 16'h6001, 16'h6000});
            check("rr_grant", last_ready, N'(1) << (c % 4));
            check("rr_operand", sqrt_input, 16'h6000 + 16'(c % 4));
        end
        for (int c = 0; c < 8; c++) begin
            man_vo = 1'b1;
            man_do = 16'h7000 + 16'(c);
            run_cycle('0, '0);
            check("rr_rsp_order", rsp_valid, N'(1) << (c % 4));
            check("rr_rsp_data", rsp_data, 16'h7000 + 16'(c));
        end
        man_vo = 1'b0;

        // Result with an empty FIFO: sticky error, no response.
        do_reset('0);
        man_vo = 1'b1;
        man_do = 16'h1234;
        run_cycle('0, '0);
        check("err_set", tag_err, 1'b1);
        check("err_no_rsp", rsp_valid, '0);
        man_vo = 1'b0;
        for (int c = 0; c < 3; c++) run_cycle('0, '0);
        check("err_sticky", tag_err, 1'b1);

        // Reset with 5 tags pending; pointer returns to 0.
        do_reset('0);
        for (int c = 0; c < 5; c++) run_cycle(4'b0100, {N{16'h2222}});
        check("pre_rst_busy", busy, 1'b1);
        do_reset(4'b1111);
        run_cycle(4'b1100, {N{16'h3333}});
        check("post_rst_grant", last_ready, 4'b0100);

        // Single op through the stub pipeline.
        do_reset('0);
        stub_en = 1'b1;
        run_cycle(4'b0001, {48'h0, 16'h4400});
        check("single_grant", last_ready, 4'b0001);
        pulses = 0;
        stray  = 0;
        for (int c = 0; c < 30; c++) begin
            run_cycle('0, '0);
            if (rsp_valid == 4'b0001 && rsp_data == 16'h4000) pulses++;
            else if (rsp_valid != '0) stray++;
        end
        check("single_pulses", 64'(pulses), 64'd1);
        check("single_stray", 64'(stray), 64'd0);
        check("single_fillers_stop", sqrt_valid_in, 1'b0);
        stub_en = 1'b0;
        man_vo  = 1'b1;
        ndrain  = m_q.size();
        for (int c = 0; c < ndrain; c++) run_cycle('0, '0);
        man_vo = 1'b0;
        run_cycle('0, '0);
        check("single_busy_low", busy, 1'b0);
        check("single_no_err", tag_err, 1'b0);

        // Randomized traffic through the stub, in phases of different load.
        do_reset('0);
        stub_en = 1'b1;
        cur_v   = '0;
        for (int i = 0; i < N; i++) cur_d[i] = '0;
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (!cur_v[i] && $urandom_range(0, 99) < pct[b]) begin
                        cur_v[i] = 1'b1;
                        cur_d[i] = 16'($urandom);
                    end
                    flat[16*i +: 16] = cur_d[i];
                end
                run_cycle(cur_v, flat);
                cur_v = cur_v & ~m_rdy;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_arbiter.md
Name: sqrt_arbiter

Overview:
- Shares one fp16 `sqrt` pipeline among NUM_REQ requesters.
- Arbitrates with a round-robin grant and issues operands to the unit.
- Records a tag per issued op in an in-order tag FIFO and routes each result back to its requester.
- The `sqrt` unit only advances its internal pipes on cycles with a valid input. The arbiter therefore injects filler ops while real ops are in flight so results drain without new traffic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_INFLIGHT, 8, tag FIFO depth and credit limit (power of 2, must be >= sqrt pipeline depth)
FILLER_VAL, 16'h3C00, operand used for filler ops (1.0)

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_data  in  16*NUM_REQ  per-requester fp16 operand; slice i = [16i+15:16i]
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
rsp_valid  out  NUM_REQ  one-hot result strobe, 1 cycle
rsp_data  out  16  result value, valid when any rsp_valid bit is set
sqrt_valid_in  out  1  to sqrt valid_data_in
sqrt_input  out  16  to sqrt input_val
sqrt_valid_out  in  1  from sqrt valid_data_out
sqrt_output  in  16  from sqrt output_val
busy  out  1  tag FIFO non-empty
tag_err  out  1  sticky: result arrived with the tag FIFO empty

Behaviour:
- Reset (synchronous, active-high, shared with the sqrt unit):
  - All outputs 0 and the RR pointer 0.
  - Tag FIFO empty; count=0, real_count=0; tag_err=0.
  - Reset mid-operation discards all in-flight tags.
- Grant (combinational):
  - Credit is ok when count < MAX_INFLIGHT.
  - Scan req_valid starting at the RR pointer and wrap; the first set bit wins.
  - req_ready[i]=1 only for the winner and only when credit is ok.
  - A requester must hold req_valid/req_data until req_ready.
  - No same-cycle pop bypass: a full FIFO blocks grants even when a result pops that cycle.
- Accept cycle (req_valid[i] & req_ready[i]):
  - Next cycle: sqrt_valid_in=1 and sqrt_input=req_data slice i (registered issue, 1-cycle latency).
  - Push tag {filler=0, idx=i}; real_count+1.
  - RR pointer becomes (i+1) mod NUM_REQ.
- Filler issue:
  - Condition: no accept this cycle, real_count>0, and credit ok.
  - Next cycle: sqrt_valid_in=1 and sqrt_input=FILLER_VAL.
  - Push tag {filler=1}. The RR pointer is unchanged.
- Idle: otherwise sqrt_valid_in=0 and sqrt_input holds its last value.
- Result cycle (sqrt_valid_out=1):
  - Pop the head tag.
  - Real tag: next cycle rsp_valid = one-hot(idx) and rsp_data=sqrt_output; real_count-1.
  - Filler tag: dropped and rsp_valid stays 0.
  - FIFO empty: set tag_err, no pop, no response.
- Counters:
  - count tracks FIFO occupancy; simultaneous push and pop leave it unchanged.
  - Pointers wrap modulo MAX_INFLIGHT.
- Ordering: responses return in issue order, with at most one response per cycle.
- busy = (count != 0).

Optional Feature:
- Macro: SQRT_ARB_PERF_EN.
- When defined, add outputs perf_issued[31:0] (real ops accepted), perf_filler[31:0] (filler ops issued) and perf_stall[31:0] (cycles with any req_valid but no credit).
  - All three are wrapping counters, cleared by RST.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single op: req 0 sends 16'h4400 (4.0), nothing else → sqrt_valid_in for 1 cycle, then filler ops each cycle until the result → rsp_valid=4'b0001 with rsp_data≈16'h4000; fillers dropped; busy falls when the FIFO empties.
- Round-robin: req_valid=4'b1111 held for 8 cycles → grant order 0,1,2,3,0,1,2,3; rsp_valid one-hot order matches; no fillers issued.
- Credit: MAX_INFLIGHT=8, all requesters continuously valid, results withheld → exactly 8 accepts, req_ready=0 and no filler; a sqrt_valid_out pop lets grants resume one cycle later.
- Filler drop: one op issued, then idle → the FIFO contains 1 real tag followed by fillers; only one rsp_valid pulse seen; real_count returns to 0 and fillers stop issuing.
- Error: sqrt_valid_out=1 forced with the FIFO empty → tag_err=1 and held until RST; no rsp_valid.
- Reset mid-flight: RST asserted with 5 tags pending → next cycle count=0, busy=0, rsp_valid=0, RR pointer=0; a new request to 2 is granted first.
